// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow E/M/W destination records drive D-stage
// stall and forwarding decisions, plus the MDU busy window and flush clearing.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_rs,
    output logic [1:0] fwd_rt,
    output logic       md_busy
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [TNEW_W-1:0] TUSE_NONE = TNEW_W'(3);
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // In-flight producer record; the MDU flag is only needed while in E and
    // W results are always ready, so those stages keep only what they use.
    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [TNEW_W-1:0] tnew;
    } data_rec_t;

    data_rec_t        e_q;
    data_rec_t        m_q;
    logic             e_md_q;
    logic [REG_W-1:0] w_dst_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             md_busy_q;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic issue;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    function automatic logic hit(input logic [REG_W-1:0] s, input logic [REG_W-1:0] dst);
        return (s != '0) && (dst == s);
    endfunction

    function automatic logic data_stall(input logic [REG_W-1:0]  s,
                                        input logic [TNEW_W-1:0] tuse,
                                        input data_rec_t         e,
                                        input data_rec_t         m);
        if (tuse == TUSE_NONE) begin
            return 1'b0;
        end
        return (hit(s, e.dst) && (e.tnew > tuse)) || (hit(s, m.dst) && (m.tnew > tuse));
    endfunction

    // Priority: E result ready, then M result ready, then anything in W.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] s,
                                           input data_rec_t        e,
                                           input data_rec_t        m,
                                           input logic [REG_W-1:0] w_dst);
        if (hit(s, e.dst) && (e.tnew == '0)) begin
            return FWD_E;
        end
        if (hit(s, m.dst) && (m.tnew == '0)) begin
            return FWD_M;
        end
        if (hit(s, w_dst)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    // Zero-latency hazard decode.
    always_comb begin
        stall_rs = data_stall(d_rs, d_tuse_rs, e_q, m_q);
        stall_rt = data_stall(d_rt, d_tuse_rt, e_q, m_q);
        stall_md = d_md_use && md_busy_q;
        stall    = (stall_rs || stall_rt || stall_md) && !flush;
        issue    = !stall && !flush;
        fwd_rs   = fwd_sel(d_rs, e_q, m_q, w_dst_q);
        fwd_rt   = fwd_sel(d_rt, e_q, m_q, w_dst_q);
    end

    // MDU busy counter: a flush kills an op still in E; an op past E finishes.
    always_comb begin
        cnt_nxt = cnt_q;
        if (flush && e_md_q) begin
            cnt_nxt = '0;
        end else if (d_md_start && issue) begin
            cnt_nxt = d_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_nxt = cnt_q - CNT_W'(1);
        end
    end

    assign md_busy = md_busy_q;

    // E/M/W never stall; W still takes the old M on a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q       <= '0;
            e_md_q    <= 1'b0;
            m_q       <= '0;
            w_dst_q   <= '0;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
        end else begin
            if (issue) begin
                e_q.dst  <= d_dst;
                e_q.tnew <= d_tnew;
                e_md_q   <= d_md_start;
            end else begin
                e_q    <= '0;
                e_md_q <= 1'b0;
            end
            if (flush) begin
                m_q <= '0;
            end else begin
                m_q.dst  <= e_q.dst;
                m_q.tnew <= sat_dec(e_q.tnew);
            end
            w_dst_q   <= m_q.dst;
            cnt_q     <= cnt_nxt;
            md_busy_q <= (cnt_nxt != '0);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random
// traffic compared against a queue-style pipeline model kept in the bench.
module tb_hazard_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use, flush;
    logic       stall, md_busy;
    logic [1:0] fwd_rs, fwd_rt;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: index 0 = E, 1 = M, 2 = W.
    int p_dst[3];
    int p_tnew[3];
    int e_md;
    int cnt;
    int exp_stall;

    hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_dstall(int s, int t);
        if (t == 3 || s == 0) return 0;
        for (int i = 0; i < 2; i++)
            if (p_dst[i] == s && p_tnew[i] > t) return 1;
        return 0;
    endfunction

    function automatic int m_fwd(int s);
        if (s == 0) return 0;
        if (p_dst[0] == s && p_tnew[0] == 0) return 1;
        if (p_dst[1] == s && p_tnew[1] == 0) return 2;
        if (p_dst[2] == s) return 3;
        return 0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) begin
            p_dst[i]  = 0;
            p_tnew[i] = 0;
        end
        e_md = 0;
        cnt  = 0;
    endfunction

    function automatic void m_step();
        int iss;
        if (reset) begin
            m_reset();
            return;
        end
        iss = (exp_stall == 0 && flush == 0);
        if (flush && e_md) cnt = 0;
        else if (d_md_start && iss) cnt = d_md_div ? DIV_CYC : MULT_CYC;
        else if (cnt > 0) cnt = cnt - 1;
        for (int i = 2; i >= 1; i--) begin
            p_dst[i]  = p_dst[i-1];
            p_tnew[i] = (p_tnew[i-1] > 0) ? p_tnew[i-1] - 1 : 0;
        end
        if (flush) begin
            p_dst[1]  = 0;
            p_tnew[1] = 0;
        end
        p_dst[0]  = iss ? int'(d_dst) : 0;
        p_tnew[0] = iss ? int'(d_tnew) : 0;
        e_md      = iss ? int'(d_md_start) : 0;
    endfunction

    task automatic nop();
        reset = 0; flush = 0;
        d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3;
        d_dst = 0; d_tnew = 0;
        d_md_start = 0; d_md_div = 0; d_md_use = 0;
    endtask

    // Inputs already driven after a falling edge: check, then clock once.
    task automatic cycle();
        #1;
        exp_stall = ((m_dstall(d_rs, d_tuse_rs) || m_dstall(d_rt, d_tuse_rt)
                     || (d_md_use && cnt > 0)) && !flush) ? 1 : 0;
        chk("stall", stall, exp_stall);
        chk("fwd_rs", fwd_rs, m_fwd(d_rs));
        chk("fwd_rt", fwd_rt, m_fwd(d_rt));
        chk("md_busy", md_busy, (cnt > 0) ? 1 : 0);
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic md_test(input logic div, input int exp_busy, input int exp_stalls);
        int busy_n = 0;
        int stall_n = 0;
        nop(); d_md_start = 1; d_md_div = div; d_md_use = 1;
        cycle();
        for (int k = 0; k < 15; k++) begin
            nop();
            if (k > 0) d_md_use = 1;
            #1;
            if (md_busy) busy_n++;
            if (stall) stall_n++;
            cycle();
        end
        chk(div ? "div_busy_len" : "mult_busy_len", busy_n, exp_busy);
        chk(div ? "div_stall_len" : "mult_stall_len", stall_n, exp_stalls);
    endtask

    initial begin
        nop();
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        m_reset();
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_fwd_rs", fwd_rs, 0);
        chk("rst_fwd_rt", fwd_rt, 0);
        chk("rst_busy", md_busy, 0);
        cycle();

        // Load-use: lw $5 then reader with tuse 1 stalls exactly one cycle.
        nop(); d_dst = 5; d_tnew = 2; cycle();
        nop(); d_rs = 5; d_tuse_rs = 1; #1; chk("lu_stall1", stall, 1); cycle();
        nop(); d_rs = 5; d_tuse_rs = 1; #1; chk("lu_stall2", stall, 0); cycle();

        // ALU to branch, back to back then with a nop between.
        nop(); d_dst = 3; d_tnew = 1; cycle();
        nop(); d_rs = 3; d_tuse_rs = 0; #1; chk("br_stall", stall, 1); cycle();
        nop(); d_rs = 3; d_tuse_rs = 0; #1; chk("br_stall_end", stall, 0);
        chk("br_fwd_m", fwd_rs, 2); cycle();
        nop(); d_dst = 3; d_tnew = 1; cycle();
        nop(); cycle();
        nop(); d_rt = 3; d_tuse_rt = 0; #1; chk("br_nop_stall", stall, 0);
        chk("br_nop_fwd", fwd_rt, 2); cycle();

        // Register zero never hazards.
        nop(); d_dst = 0; d_tnew = 1; cycle();
        for (int i = 0; i < 3; i++) begin
            nop(); d_rs = 0; d_tuse_rs = 0; #1;
            chk("r0_stall", stall, 0);
            chk("r0_fwd", fwd_rs, 0);
            cycle();
        end

        md_test(1'b1, DIV_CYC, DIV_CYC - 1);
        md_test(1'b0, MULT_CYC, MULT_CYC - 1);

        // Flush while the mult is in E kills it and its record.
        nop(); d_md_start = 1; d_md_use = 1; d_dst = 7; d_tnew = 1; cycle();
        nop(); flush = 1; #1; chk("fl_busy_pre", md_busy, 1); cycle();
        nop(); d_rs = 7; d_tuse_rs = 0; #1;
        chk("fl_busy", md_busy, 0);
        chk("fl_stall", stall, 0);
        chk("fl_fwd", fwd_rs, 0);
        cycle();

        // Reset mid-divide with dst 9 in E.
        nop(); d_md_start = 1; d_md_div = 1; d_md_use = 1; cycle();
        nop(); cycle();
        nop(); cycle();
        nop(); d_dst = 9; d_tnew = 2; cycle();
        nop(); d_rs = 9; d_tuse_rs = 0; #1; chk("pre_rst_stall", stall, 1);
        nop(); reset = 1; cycle();
        nop(); d_rs = 9; d_tuse_rs = 0; #1;
        chk("post_rst_busy", md_busy, 0);
        chk("post_rst_stall", stall, 0);
        chk("post_rst_fwd", fwd_rs, 0);
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            nop();
            d_rs       = 5'($urandom_range(0, 7));
            d_rt       = 5'($urandom_range(0, 7));
            d_tuse_rs  = 2'($urandom_range(0, 3));
            d_tuse_rt  = 2'($urandom_range(0, 3));
            d_dst      = 5'($urandom_range(0, 7));
            d_tnew     = 2'($urandom_range(0, 2));
            d_md_start = ($urandom_range(0, 11) == 0);
            d_md_div   = 1'($urandom_range(0, 1));
            d_md_use   = d_md_start || ($urandom_range(0, 5) == 0);
            flush      = ($urandom_range(0, 24) == 0);
            reset      = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
